pipe_ctrl: RTL

Central stall/flush sequencer for the 7-stage in-order pipeline. It merges per-stage stall requests into the `stall[6:0]` vector consumed by every pipeline register, including `id_ex`.
It captures exceptions and `ertn` reported by the MEM stage, drives a one-cycle `flush` together with the redirect PC, and counts stall cycles for a watchdog and for performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 34 +++
 rtl/stall_watchdog.sv | 50 +++++
 rtl/pipe_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

   // Pipeline register indices within the stall vector
   localparam int unsigned STG_PC     = 0;
   localparam int unsigned STG_IF     = 1;
   localparam int unsigned STG_IF_ID  = 2;
   localparam int unsigned STG_ID_EX  = 3;
   localparam int unsigned STG_EX_MEM = 4;
   localparam int unsigned STG_MEM_WB = 5;
   localparam int unsigned STG_WB     = 6;
   localparam int unsigned NUM_STG    = 7;

   // MEM-stage exception type codes; 2'b11 is reserved and never accepted
   localparam logic [1:0] EXC_NONE = 2'b00;
   localparam logic [1:0] EXC_TRAP = 2'b01;
   localparam logic [1:0] EXC_ERTN = 2'b10;

   // Sequencer state encoding
   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_PEND  = 2'b01;
   localparam logic [1:0] ST_FLUSH = 2'b10;

   // Stall mask covering pipeline registers 0..stg inclusive
   function automatic logic [NUM_STG-1:0] stall_upto(input int unsigned stg);
      logic [NUM_STG-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < NUM_STG; i++) begin
         if (i <= stg) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Consecutive-stall watchdog plus saturating stalled-cycle performance counter.
module stall_watchdog #(
   parameter int unsigned WDOG_LIMIT = 1024,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_stall,
   input  logic             i_flush,
   output logic             o_wdog_timeout,
   output logic [CNT_W-1:0] o_stall_cycle_cnt
);

   localparam int unsigned          RUN_W    = $clog2(WDOG_LIMIT);
   localparam logic [RUN_W-1:0]     RUN_LAST = RUN_W'(WDOG_LIMIT - 1);

   logic [RUN_W-1:0] r_run;
   logic             r_wdog;
   logic [CNT_W-1:0] r_cnt;

   // Run counter restarts on any unstalled or flushing cycle; wraps with a pulse at the limit
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_run  <= '0;
         r_wdog <= 1'b0;
      end else if (!i_stall || i_flush) begin
         r_run  <= '0;
         r_wdog <= 1'b0;
      end else if (r_run == RUN_LAST) begin
         r_run  <= '0;
         r_wdog <= 1'b1;
      end else begin
         r_run  <= r_run + 1'b1;
         r_wdog <= 1'b0;
      end
   end

   // Saturating count of all stalled cycles
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_stall && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_wdog_timeout    = r_wdog;
   assign o_stall_cycle_cnt = r_cnt;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall priority encoder and exception flush sequencer.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned WDOG_LIMIT = 1024,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stallreq_if,
   input  logic             stallreq_id,
   input  logic             stallreq_ex,
   input  logic             stallreq_mem,
   input  logic [1:0]       mem_excepttype,
   input  logic             mem_inst_valid,
   input  logic [31:0]      mem_pc,
   input  logic [31:0]      csr_eentry,
   input  logic [31:0]      csr_era,
   output logic [6:0]       stall,
   output logic             flush,
   output logic [31:0]      new_pc,
   output logic             epc_we,
   output logic [31:0]      epc_wdata,
   output logic             wdog_timeout,
   output logic [CNT_W-1:0] stall_cycle_cnt
);

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;
   logic        w_capture;
   logic        w_event;
   logic        w_flush;
   logic        r_is_trap;
   logic [31:0] r_pc;
   logic [31:0] r_target;
   logic [6:0]  w_stall;

   assign w_event = mem_inst_valid &&
                    ((mem_excepttype == EXC_TRAP) || (mem_excepttype == EXC_ERTN));
   assign w_flush = (r_state == ST_FLUSH);

   // Next-state: exceptions are only accepted from IDLE; PEND waits out the dcache miss
   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_event) begin
               w_capture   = 1'b1;
               w_state_nxt = stallreq_mem ? ST_PEND : ST_FLUSH;
            end
         end
         ST_PEND:  if (!stallreq_mem) w_state_nxt = ST_FLUSH;
         ST_FLUSH: w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // State register and captured exception context
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_is_trap <= 1'b0;
         r_pc      <= '0;
         r_target  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_capture) begin
            r_is_trap <= (mem_excepttype == EXC_TRAP);
            r_pc      <= mem_pc;
            r_target  <= (mem_excepttype == EXC_TRAP) ? csr_eentry : csr_era;
         end
      end
   end

   // Highest requesting stage wins; a flush overrides every stall
   always_comb begin
      w_stall = '0;
      if (!w_flush) begin
         if (stallreq_mem)     w_stall = stall_upto(STG_MEM_WB);
         else if (stallreq_ex) w_stall = stall_upto(STG_EX_MEM);
         else if (stallreq_id) w_stall = stall_upto(STG_ID_EX);
         else if (stallreq_if) w_stall = stall_upto(STG_IF_ID);
      end
   end

   assign stall     = w_stall;
   assign flush     = w_flush;
   assign new_pc    = w_flush ? r_target : 32'h0;
   assign epc_we    = w_flush & r_is_trap;
   assign epc_wdata = w_flush ? r_pc : 32'h0;

   stall_watchdog #(
      .WDOG_LIMIT (WDOG_LIMIT),
      .CNT_W      (CNT_W)
   ) u_stall_watchdog (
      .i_clk             (clk),
      .i_rst_n           (rst),
      .i_stall           (w_stall[STG_PC]),
      .i_flush           (w_flush),
      .o_wdog_timeout    (wdog_timeout),
      .o_stall_cycle_cnt (stall_cycle_cnt)
   );

endmodule
